// File: rtl/rf_pkg.sv
// Shared register-file types: address width, register count and write-back source tags.
package rf_pkg;

  localparam int RegAddrW = 5;
  localparam int RegsNum  = 32;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: decode marks long-latency destinations, MEM writeback releases them.
module wb_scoreboard
  import rf_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set,
  input  logic [RegAddrW-1:0] i_set_rd,
  input  logic                i_clr,
  input  logic [RegAddrW-1:0] i_clr_rd,
  output logic [RegsNum-1:0]  o_busy
);

  logic [RegsNum-1:0] busy_q, busy_d;

  // Set is applied after clear so a newer in-flight MEM op keeps its register marked.
  always_comb begin
    busy_d = busy_q;
    if (i_clr && (i_clr_rd != '0)) busy_d[i_clr_rd] = 1'b0;
    if (i_set && (i_set_rd != '0)) busy_d[i_set_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-port arbiter merging ALU and MEM results into the register file, with ALU starvation
// guard and the pending-write scoreboard used by decode.
module reg_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_alu_valid,
  output logic                 o_alu_ready,
  input  logic [RegAddrW-1:0]  i_alu_rd,
  input  logic [DataWidth-1:0] i_alu_data,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [RegAddrW-1:0]  i_mem_rd,
  input  logic [DataWidth-1:0] i_mem_data,
  input  logic                 i_sb_set,
  input  logic [RegAddrW-1:0]  i_sb_rd,
  output logic [RegsNum-1:0]   o_busy,
  output logic [RegAddrW-1:0]  o_wreg,
  output logic [DataWidth-1:0] o_wdata,
  output logic                 o_we
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0]           starve_q, starve_d;
  logic                 we_q, we_d;
  logic [RegAddrW-1:0]  wreg_q, wreg_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 force_alu;
  wb_src_e              grant;

  // MEM normally has priority; ALU wins only once it has been refused StarveLimit times.
  assign force_alu   = (starve_q == StarveMax);
  assign o_alu_ready = !i_mem_valid || force_alu;
  assign o_mem_ready = !(i_alu_valid && force_alu);

  always_comb begin
    grant = WB_NONE;
    if (i_alu_valid && o_alu_ready)      grant = WB_ALU;
    else if (i_mem_valid && o_mem_ready) grant = WB_MEM;
  end

  always_comb begin
    starve_d = starve_q;
    if (grant == WB_ALU)                  starve_d = '0;
    else if (i_alu_valid && !o_alu_ready) starve_d = starve_q + 4'd1;
  end

  // Address/data hold when idle; x0 results complete the handshake but never write.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    case (grant)
      WB_ALU: begin
        we_d    = (i_alu_rd != '0);
        wreg_d  = i_alu_rd;
        wdata_d = i_alu_data;
      end
      WB_MEM: begin
        we_d    = (i_mem_rd != '0);
        wreg_d  = i_mem_rd;
        wdata_d = i_mem_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_we    = we_q;
  assign o_wreg  = wreg_q;
  assign o_wdata = wdata_q;

  wb_scoreboard u_scoreboard (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_set    (i_sb_set),
    .i_set_rd (i_sb_rd),
    .i_clr    (grant == WB_MEM),
    .i_clr_rd (i_mem_rd),
    .o_busy   (o_busy)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: vector table with an expected-write queue, plus a reset-during-contention sequence.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, sb_rd, wreg;
  logic [31:0] alu_data, mem_data, wdata, busy;
  logic        sb_set, we;

  reg_wb_arbiter #(.DataWidth(32), .StarveLimit(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .i_mem_valid (mem_valid),
    .o_mem_ready (mem_ready),
    .i_mem_rd    (mem_rd),
    .i_mem_data  (mem_data),
    .i_sb_set    (sb_set),
    .i_sb_rd     (sb_rd),
    .o_busy      (busy),
    .o_wreg      (wreg),
    .o_wdata     (wdata),
    .o_we        (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        set;
    logic [4:0]  srd;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  ewreg;
    logic [31:0] ewdata;
    logic        echk;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        chk;
  } exp_t;

  vec_t        vecs[$];
  exp_t        expq[$];
  logic [31:0] busy_m;
  int          n_pass = 0;
  int          n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic set, input logic [4:0] srd);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    sb_set = set; sb_rd = srd;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    busy_m = '0;

    //          av ard  adat          mv mrd mdat   set srd ear emr ewe wreg wdata         chk
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  1, 1, 0, 0,  32'h0,        1});
    vecs.push_back('{1, 5, 32'hDEADBEEF, 0, 0,  32'h0,  0, 0,  1, 1, 1, 5,  32'hDEADBEEF, 1});
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  1, 1, 0, 5,  32'hDEADBEEF, 1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  0, 1, 1, 7,  32'h77,       1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  0, 1, 1, 7,  32'h77,       1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  0, 1, 1, 7,  32'h77,       1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  0, 1, 1, 7,  32'h77,       1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  1, 0, 1, 3,  32'h33,       1});
    vecs.push_back('{1, 3, 32'h33,       1, 7,  32'h77, 0, 0,  0, 1, 1, 7,  32'h77,       1});
    vecs.push_back('{1, 0, 32'h1234,     0, 0,  32'h0,  0, 0,  1, 1, 0, 0,  32'h0,        0});
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  1, 9,  1, 1, 0, 0,  32'h0,        0});
    vecs.push_back('{0, 0, 32'h0,        1, 9,  32'h99, 1, 9,  0, 1, 1, 9,  32'h99,       1});
    vecs.push_back('{0, 0, 32'h0,        1, 9,  32'h9A, 0, 0,  0, 1, 1, 9,  32'h9A,       1});
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  1, 0,  1, 1, 0, 9,  32'h9A,       1});
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  1, 6,  1, 1, 0, 9,  32'h9A,       1});
    vecs.push_back('{0, 0, 32'h0,        1, 6,  32'h66, 1, 4,  0, 1, 1, 6,  32'h66,       1});
    vecs.push_back('{0, 0, 32'h0,        1, 11, 32'hB,  0, 0,  0, 1, 1, 11, 32'hB,        1});
    vecs.push_back('{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  1, 1, 0, 11, 32'hB,        1});

    #2;
    check("reset_we", 32'(we), 0);
    check("reset_wreg", 32'(wreg), 0);
    check("reset_wdata", wdata, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.av, v.ard, v.adat, v.mv, v.mrd, v.mdat, v.set, v.srd);
      #1;
      check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(v.ear));
      check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(v.emr));
      expq.push_back('{v.ewe, v.ewreg, v.ewdata, v.echk});
      @(posedge clk); #1;
      if (v.mv && v.emr && v.mrd != 0) busy_m[v.mrd] = 1'b0;
      if (v.set && v.srd != 0) busy_m[v.srd] = 1'b1;
      if (expq.size() == 0) begin
        check($sformatf("v%0d_queue_empty", i), 1, 0);
      end else begin
        e = expq.pop_front();
        check($sformatf("v%0d_we", i), 32'(we), 32'(e.we));
        if (e.chk) begin
          check($sformatf("v%0d_wreg", i), 32'(wreg), 32'(e.wreg));
          check($sformatf("v%0d_wdata", i), wdata, e.wdata);
        end
      end
      check($sformatf("v%0d_busy", i), busy, busy_m);
    end

    // Build up starvation to the limit, then reset mid-cycle with both sources still valid.
    drive(1, 3, 32'h33, 1, 12, 32'hC0, 1, 20);
    @(posedge clk); #1;
    sb_set = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_force_alu", 32'(alu_ready), 1);
    rst_n = 1'b0;
    #1;
    check("in_reset_we", 32'(we), 0);
    check("in_reset_wreg", 32'(wreg), 0);
    check("in_reset_wdata", wdata, 0);
    check("in_reset_busy", busy, 0);
    check("in_reset_starve_clear", 32'(alu_ready), 0);
    check("in_reset_mem_ready", 32'(mem_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    check("in_reset_we_held", 32'(we), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_reset_mem_ready", 32'(mem_ready), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_c%0d_we", k), 32'(we), 1);
      check($sformatf("post_reset_c%0d_wreg", k), 32'(wreg), (k < 4) ? 32'd12 : 32'd3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("final_idle_we", 32'(we), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
